// File: rtl/arc_trigonometric_if.sv
// Request/result bundle for the arc-sine / arc-cosine converter.
// The master issues start with operands; the slave returns busy, done and the angle.
interface arc_trigonometric_if;
   logic        start;
   logic [9:0]  value;
   logic        neg;
   logic        iscos;
   logic        busy;
   logic        done;
   logic [11:0] degree;

   modport master (
      output start, value, neg, iscos,
      input  busy, done, degree
   );

   modport slave (
      input  start, value, neg, iscos,
      output busy, done, degree
   );
endinterface

// File: rtl/arc_trigonometric.sv
// Arc-sine / arc-cosine by binary search over a registered quarter-wave sine ROM.
// Result is an angle in 0.1 degree units, 0..3599.

// Behavioural model of the sine_LUT ROM: q = floor(1023*sin(address*0.1 deg)),
// using the Bhaskara approximation so the table is built from integer math only.
module sine_LUT (
   input  logic [9:0] address,
   input  logic       clock,
   output logic [9:0] q
);
   function automatic logic [9:0] sine_val(input int t);
      longint p;
      longint d;
      longint n;
      if (t >= 900) return 10'd1023;
      p = longint'(t) * longint'(1800 - t);
      d = 64'd4050000 - p;
      n = 64'd4092 * p;
      return 10'(n / d);
   endfunction

   logic [9:0] rom [0:1023];

   for (genvar g = 0; g < 1024; g++) begin : g_rom
      assign rom[g] = sine_val(g);
   end

   // NOTE: the ROM output register carries no reset; it is pure data path and
   // is only consumed one cycle after an address has been presented.
   always_ff @(posedge clock) begin
      q <= rom[address];
   end
endmodule

module arc_trigonometric #(
   parameter int ITER    = 10,
   parameter int MAXADDR = 900
) (
   input logic                clk,
   input logic                rst,
   arc_trigonometric_if.slave bus
);
   localparam int CW = $clog2(ITER + 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      CMP,
      FIN
   } state_t;

   if ((1 << ITER) < (MAXADDR + 1)) begin : g_param_check
      $error("ITER too small to cover 0..MAXADDR");
   end

   state_t        state, state_d;
   logic [9:0]    lo, lo_d;
   logic [9:0]    hi, hi_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic [9:0]    val_q, val_d;
   logic          neg_q, neg_d;
   logic          iscos_q, iscos_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [11:0]   deg_q, deg_d;
   logic [9:0]    mid;
   logic [9:0]    q;
   logic [11:0]   a_ext;

   // Midpoint formed in 11 bits so lo+hi cannot overflow before the halving.
   assign mid     = 10'((11'(lo) + 11'(hi)) >> 1);
   assign cnt_inc = cnt + CW'(1);
   assign a_ext   = {2'b00, lo};

   sine_LUT u_lut (
      .address(mid),
      .clock  (clk),
      .q      (q)
   );

   always_comb begin
      // NOTE: every variable gets its hold value first so no path infers a latch.
      state_d = state;
      lo_d    = lo;
      hi_d    = hi;
      cnt_d   = cnt;
      val_d   = val_q;
      neg_d   = neg_q;
      iscos_d = iscos_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      deg_d   = deg_q;

      unique case (state)
         IDLE: begin
            if (bus.start) begin
               val_d   = bus.value;
               neg_d   = bus.neg;
               iscos_d = bus.iscos;
               lo_d    = '0;
               hi_d    = 10'(MAXADDR);
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = READ;
            end
         end
         READ: begin
            state_d = CMP;
         end
         CMP: begin
            // Once lo==hi the bounds freeze, so every conversion runs ITER rounds.
            if (lo < hi) begin
               if (q >= val_q) hi_d = mid;
               else            lo_d = mid + 10'd1;
            end
            cnt_d   = cnt_inc;
            state_d = (cnt_inc < CW'(ITER)) ? READ : FIN;
         end
         FIN: begin
            unique case ({iscos_q, neg_q})
               2'b00: deg_d = a_ext;
               2'b01: deg_d = (lo == 10'd0) ? 12'd0 : 12'd3600 - a_ext;
               2'b10: deg_d = 12'd900 - a_ext;
               2'b11: deg_d = 12'd900 + a_ext;
               default: deg_d = a_ext;
            endcase
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         lo      <= '0;
         hi      <= '0;
         cnt     <= '0;
         val_q   <= '0;
         neg_q   <= 1'b0;
         iscos_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         deg_q   <= '0;
      end else begin
         state   <= state_d;
         lo      <= lo_d;
         hi      <= hi_d;
         cnt     <= cnt_d;
         val_q   <= val_d;
         neg_q   <= neg_d;
         iscos_q <= iscos_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         deg_q   <= deg_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.degree = deg_q;

   a_done_single : assert property (@(posedge clk) disable iff (rst) done_q |=> !done_q);
   a_done_idle   : assert property (@(posedge clk) disable iff (rst) done_q |-> !busy_q);
   a_deg_range   : assert property (@(posedge clk) disable iff (rst) deg_q < 12'd3600);
endmodule

// File: tb/tb_arc_trigonometric.sv
// Directed-vector bench for arc_trigonometric: table of hand-computed results,
// a full value sweep against a ceiling-search model, held-start and mid-run reset.
module tb_arc_trigonometric;
   logic clk = 1'b0;
   logic rst = 1'b1;

   arc_trigonometric_if bus ();

   arc_trigonometric #(
      .ITER   (10),
      .MAXADDR(900)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      string      name;
      logic [9:0] value;
      logic       neg;
      logic       iscos;
      int         exp_deg;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference sine table: floor(1023 * Bhaskara-sine(t * 0.1 deg)).
   function automatic int lut_val(input int t);
      longint p;
      if (t >= 900) return 1023;
      p = longint'(t) * longint'(1800 - t);
      return int'((64'd4092 * p) / (64'd4050000 - p));
   endfunction

   // Linear ceiling search for the smallest address reaching v, then quadrant map.
   function automatic int model_deg(input int v, input bit n, input bit ic);
      int a;
      a = 0;
      while (a < 900 && lut_val(a) < v) a++;
      if (!ic && !n) return a;
      if (!ic && n)  return (a == 0) ? 0 : 3600 - a;
      if (ic && !n)  return 900 - a;
      return 900 + a;
   endfunction

   task automatic run_conv(input logic [9:0] v, input logic n, input logic ic,
                           output int deg, output int lat, output int busy_seen);
      @(negedge clk);
      bus.start = 1'b1;
      bus.value = v;
      bus.neg   = n;
      bus.iscos = ic;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      busy_seen = int'(bus.busy);
      lat = -1;
      deg = -1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done) begin
            lat = c;
            deg = int'(bus.degree);
            break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int deg, lat, bsy, ndone;
      int dc [4];
      int dd [4];

      vecs[0]  = '{"asin_zero_pos", 10'd0,    1'b0, 1'b0, 0};
      vecs[1]  = '{"asin_full_pos", 10'd1023, 1'b0, 1'b0, 900};
      vecs[2]  = '{"asin_full_neg", 10'd1023, 1'b1, 1'b0, 2700};
      vecs[3]  = '{"acos_zero_pos", 10'd0,    1'b0, 1'b1, 900};
      vecs[4]  = '{"acos_zero_neg", 10'd0,    1'b1, 1'b1, 900};
      vecs[5]  = '{"acos_full_neg", 10'd1023, 1'b1, 1'b1, 1800};
      vecs[6]  = '{"acos_full_pos", 10'd1023, 1'b0, 1'b1, 0};
      vecs[7]  = '{"asin_zero_neg", 10'd0,    1'b1, 1'b0, 0};
      vecs[8]  = '{"asin_half_pos", 10'd512,  1'b0, 1'b0, 301};
      vecs[9]  = '{"asin_half_neg", 10'd512,  1'b1, 1'b0, 3299};
      vecs[10] = '{"acos_half_pos", 10'd512,  1'b0, 1'b1, 599};
      vecs[11] = '{"acos_half_neg", 10'd512,  1'b1, 1'b1, 1201};
      vecs[12] = '{"asin_511_pos",  10'd511,  1'b0, 1'b0, 300};
      vecs[13] = '{"asin_one_neg",  10'd1,    1'b1, 1'b0, 3599};

      bus.start = 1'b0;
      bus.value = '0;
      bus.neg   = 1'b0;
      bus.iscos = 1'b0;

      #1;
      check("reset_busy",   int'(bus.busy),   0);
      check("reset_done",   int'(bus.done),   0);
      check("reset_degree", int'(bus.degree), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Directed table
      foreach (vecs[i]) begin
         run_conv(vecs[i].value, vecs[i].neg, vecs[i].iscos, deg, lat, bsy);
         check({vecs[i].name, "_degree"},  deg, vecs[i].exp_deg);
         check({vecs[i].name, "_latency"}, lat, 21);
         check({vecs[i].name, "_busy"},    bsy, 1);
         @(posedge clk);
         @(negedge clk);
         check({vecs[i].name, "_done_one_cycle"}, int'(bus.done), 0);
         check({vecs[i].name, "_degree_hold"},    int'(bus.degree), vecs[i].exp_deg);
      end

      // start held high: operand changes mid-run must not leak into a conversion
      @(negedge clk);
      bus.start = 1'b1;
      bus.value = 10'd1023;
      bus.neg   = 1'b0;
      bus.iscos = 1'b0;
      ndone = 0;
      for (int c = 0; c <= 70; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done) begin
            if (ndone < 4) begin
               dc[ndone] = c;
               dd[ndone] = int'(bus.degree);
            end
            ndone++;
         end
         if (c == 5) bus.value = 10'd0;
         if (c == 30) begin
            bus.value = 10'd1023;
            bus.neg   = 1'b1;
         end
         if (c == 65) bus.start = 1'b0;
      end
      check("held_done_count", ndone, 3);
      if (ndone >= 3) begin
         check("held_done0_cycle", dc[0], 21);
         check("held_done1_cycle", dc[1], 43);
         check("held_done2_cycle", dc[2], 65);
         check("held_deg0", dd[0], 900);
         check("held_deg1", dd[1], 0);
         check("held_deg2", dd[2], 2700);
      end

      // Reset at cycle 10 of a conversion
      @(negedge clk);
      bus.start = 1'b1;
      bus.value = 10'd512;
      bus.neg   = 1'b0;
      bus.iscos = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      check("pre_reset_busy", int'(bus.busy), 1);
      rst = 1'b1;
      #1;
      check("mid_reset_busy",   int'(bus.busy),   0);
      check("mid_reset_done",   int'(bus.done),   0);
      check("mid_reset_degree", int'(bus.degree), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done) ndone++;
      end
      check("post_reset_no_done", ndone, 0);
      run_conv(10'd512, 1'b0, 1'b0, deg, lat, bsy);
      check("post_reset_degree",  deg, 301);
      check("post_reset_latency", lat, 21);

      // Full value sweep, rotating through the four sign/function combinations
      for (int v = 0; v < 1024; v++) begin
         int  combo;
         bit  n;
         bit  ic;
         combo = (v + v / 4) % 4;
         n  = combo[0];
         ic = combo[1];
         run_conv(10'(v), n, ic, deg, lat, bsy);
         check($sformatf("sweep_v%0d_n%0d_c%0d", v, n, ic), deg, model_deg(v, n, ic));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
